ram_arbiter: RTL and testbench

Two-requester arbiter sharing a single RAM port between the ALU (port 0) and a secondary master (port 1, e.g. loader or debug DMA). Both sides use the pulse-request / pulse-acknowledge protocol: a requester pulses `readReq`/`writeReq` for one cycle and waits for a one-cycle ack. The arbiter latches requests, serialises them onto the RAM port one at a time and routes each acknowledge and its read data back to the owning requester.

---
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between two pulse-protocol requesters; define ARBITER_ROUND_ROBIN_EN for round-robin, else port 0 has fixed priority
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readReq0,
  input  logic                  writeReq0,
  input  logic [ADDR_WIDTH-1:0] ramAddress0,
  input  logic [DATA_WIDTH-1:0] ramOut0,
  output logic [DATA_WIDTH-1:0] ramIn0,
  output logic                  readAck0,
  output logic                  writeAck0,
  input  logic                  readReq1,
  input  logic                  writeReq1,
  input  logic [ADDR_WIDTH-1:0] ramAddress1,
  input  logic [DATA_WIDTH-1:0] ramOut1,
  output logic [DATA_WIDTH-1:0] ramIn1,
  output logic                  readAck1,
  output logic                  writeAck1,
  output logic                  memReadReq,
  output logic                  memWriteReq,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memOut,
  input  logic [DATA_WIDTH-1:0] memIn,
  input  logic                  memReadAck,
  input  logic                  memWriteAck,
  output logic [1:0]            grant,
  output logic                  protoError
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0] state;
  logic [1:0] slot_v, slot_w, rd, wr, rack, wack, clr;
  logic [ADDR_WIDTH-1:0] slot_a [2];
  logic [DATA_WIDTH-1:0] slot_d [2];
  logic [ADDR_WIDTH-1:0] req_a [2];
  logic [DATA_WIDTH-1:0] req_d [2];
  logic [DATA_WIDTH-1:0] rin [2];
  logic last, win, own, hit;
  assign rd = {readReq1, readReq0};
  assign wr = {writeReq1, writeReq0};
  assign req_a[0] = ramAddress0;
  assign req_a[1] = ramAddress1;
  assign req_d[0] = ramOut0;
  assign req_d[1] = ramOut1;
  assign own = grant[1];
  assign hit = state == WAIT && (slot_w[own] ? memWriteAck : memReadAck);
  assign clr = hit ? (own ? 2'b10 : 2'b01) : 2'b00;
`ifdef ARBITER_ROUND_ROBIN_EN
  assign win = &slot_v ? ~last : slot_v[1];
`else
  assign win = ~slot_v[0];
`endif
  assign {readAck1, readAck0} = rack;
  assign {writeAck1, writeAck0} = wack;
  assign ramIn0 = rin[0];
  assign ramIn1 = rin[1];
  // capture request pulses into per-port slots; a slot freed by this cycle's ack may be refilled at once
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      slot_v <= '0;
      slot_w <= '0;
      protoError <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        slot_a[i] <= '0;
        slot_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr[i]) slot_v[i] <= 1'b0;
        if (rd[i] || wr[i]) begin
          if (slot_v[i] && !clr[i]) protoError <= 1'b1;
          else begin
            slot_v[i] <= 1'b1;
            slot_w[i] <= wr[i];
            slot_a[i] <= req_a[i];
            slot_d[i] <= req_d[i];
          end
          if (rd[i] && wr[i]) protoError <= 1'b1;
        end
      end
    end
  // issue one slot to the RAM, then wait for its matching ack and route it back to the owner
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      grant <= '0;
      memReadReq <= 1'b0;
      memWriteReq <= 1'b0;
      memAddress <= '0;
      memOut <= '0;
      rack <= '0;
      wack <= '0;
      for (int i = 0; i < 2; i++) rin[i] <= '0;
    end else begin
      memReadReq <= 1'b0;
      memWriteReq <= 1'b0;
      rack <= '0;
      wack <= '0;
      if (state == IDLE) begin
        if (|slot_v) begin
          state <= WAIT;
          grant <= win ? 2'b10 : 2'b01;
          memAddress <= slot_a[win];
          if (slot_w[win]) memOut <= slot_d[win];
          memReadReq <= ~slot_w[win];
          memWriteReq <= slot_w[win];
        end
      end else if (hit) begin
        state <= IDLE;
        grant <= '0;
        last <= own;
        rack[own] <= ~slot_w[own];
        wack[own] <= slot_w[own];
        if (!slot_w[own]) rin[own] <= memIn;
      end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench with a RAM model and an arbitration reference model
module tb_ram_arbiter;
  logic clk = 0, reset = 1;
  logic readReq0, writeReq0, readReq1, writeReq1, memReadAck, memWriteAck;
  logic [31:0] ramAddress0, ramOut0, ramAddress1, ramOut1, memIn;
  logic [31:0] ramIn0, ramIn1, memAddress, memOut;
  logic readAck0, writeAck0, readAck1, writeAck1, memReadReq, memWriteReq, protoError;
  logic [1:0] grant;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .readReq0(readReq0), .writeReq0(writeReq0), .ramAddress0(ramAddress0), .ramOut0(ramOut0),
    .ramIn0(ramIn0), .readAck0(readAck0), .writeAck0(writeAck0),
    .readReq1(readReq1), .writeReq1(writeReq1), .ramAddress1(ramAddress1), .ramOut1(ramOut1),
    .ramIn1(ramIn1), .readAck1(readAck1), .writeAck1(writeAck1),
    .memReadReq(memReadReq), .memWriteReq(memWriteReq), .memAddress(memAddress), .memOut(memOut),
    .memIn(memIn), .memReadAck(memReadAck), .memWriteAck(memWriteAck),
    .grant(grant), .protoError(protoError)
  );

  always #5 clk = ~clk;

  typedef struct { bit w; logic [31:0] d; } exp_t;
  exp_t q0[$], q1[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit busy [2], iss [2], pw [2];
  logic [31:0] pa [2], pd [2], exp_ramin [2];
  int req_cyc [2], ack_due [2];
  int last = 1, exp_err_cyc = -1, ram_own, ram_cnt, n_issue = 0;
  bit ram_busy = 0, ram_w, auto_ack = 1, noisy = 0;
  logic [31:0] ram_addr, ram_data;
  logic [1:0] gseq[$];
  bit wseq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] seed_val(logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  // requester side: drive a pulse and record what the arbiter owes this port
  task automatic issue(int p, bit r, bit w, logic [31:0] a, logic [31:0] d);
    exp_t e;
    if (p == 0) begin readReq0 = r; writeReq0 = w; ramAddress0 = a; ramOut0 = d; end
    else begin readReq1 = r; writeReq1 = w; ramAddress1 = a; ramOut1 = d; end
    if ((busy[p] || (r && w)) && exp_err_cyc < 0) exp_err_cyc = cyc + 1;
    if (busy[p]) return;
    busy[p] = 1; iss[p] = 0; req_cyc[p] = cyc; pw[p] = w; pa[p] = a; pd[p] = d;
    e.w = w;
    e.d = w ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : seed_val(a));
    if (w) ref_mem[a] = d;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic rand_issue(int p);
    logic [31:0] a;
    bit w, both;
    a = p == 0 ? 32'($urandom_range(0, 11)) * 4 : 32'h100 + 32'($urandom_range(0, 7)) * 4;
    both = $urandom_range(0, 19) == 0;
    w = $urandom_range(0, 1) == 1 || both;
    issue(p, !w || both, w, a, $urandom);
  endtask

  // RAM side: a new request must go to the port the arbitration rules pick
  task automatic ram_issue();
    int o, ew;
    bit e0, e1;
    chk("ram_no_overlap", ram_busy, 0);
    chk("grant_onehot", grant == 2'b01 || grant == 2'b10, 1);
    o = grant[1] ? 1 : 0;
    e0 = busy[0] && !iss[0] && req_cyc[0] <= cyc - 2;
    e1 = busy[1] && !iss[1] && req_cyc[1] <= cyc - 2;
`ifdef ARBITER_ROUND_ROBIN_EN
    ew = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
`else
    ew = e0 ? 0 : 1;
`endif
    chk("winner_pending", e0 || e1, 1);
    chk("winner", o, ew);
    chk("req_single", memReadReq ^ memWriteReq, 1);
    chk("req_kind", memWriteReq, pw[o]);
    chk("req_addr", memAddress, pa[o]);
    if (pw[o]) chk("req_wdata", memOut, pd[o]);
    ram_busy = 1; ram_own = o; ram_w = memWriteReq; ram_addr = memAddress; ram_data = memOut;
    ram_cnt = $urandom_range(0, 3); iss[o] = 1; n_issue++;
    gseq.push_back(grant); wseq.push_back(memWriteReq);
  endtask

  task automatic ram_ack();
    memReadAck = !ram_w; memWriteAck = ram_w;
    if (ram_w) mem[ram_addr] = ram_data;
    else memIn = mem.exists(ram_addr) ? mem[ram_addr] : seed_val(ram_addr);
    ack_due[ram_own] = cyc + 1; busy[ram_own] = 0; iss[ram_own] = 0; last = ram_own; ram_busy = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    readReq0 = 0; writeReq0 = 0; readReq1 = 0; writeReq1 = 0;
    memReadAck = 0; memWriteAck = 0; memIn = $urandom;
    if (memReadReq || memWriteReq) ram_issue();
    if (ram_busy && auto_ack) begin
      if (ram_cnt == 0) ram_ack();
      else begin
        ram_cnt--;
        if (noisy && $urandom_range(0, 3) == 0) begin memReadAck = ram_w; memWriteAck = !ram_w; end
      end
    end else if (!ram_busy && noisy && $urandom_range(0, 7) == 0) {memReadAck, memWriteAck} = 2'($urandom_range(1, 2));
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    for (int p = 0; p < 2; p++) begin busy[p] = 0; iss[p] = 0; exp_ramin[p] = 0; end
    ram_busy = 0; last = 1; exp_err_cyc = -1;
  endtask

  task automatic drain();
    auto_ack = 1;
    for (int i = 0; i < 200 && (busy[0] || busy[1] || ram_busy); i++) tick();
    chk("drain_done", busy[0] || busy[1] || ram_busy, 0);
    tick(); tick();
  endtask

  task automatic mon(int p, logic ra, logic wa, logic [31:0] ri);
    exp_t e;
    int n;
    if (ra || wa) begin
      n = p == 0 ? q0.size() : q1.size();
      chk("ack_queued", n > 0, 1);
      chk("ack_onehot", ra && wa, 0);
      if (n > 0) begin
        if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk("ack_kind", wa, e.w);
        chk("ack_latency", cyc, ack_due[p]);
        if (!e.w) exp_ramin[p] = e.d;
      end
    end
    chk(p == 0 ? "ramin0" : "ramin1", ri, exp_ramin[p]);
  endtask

  // scoreboard monitor: pops the expected response whenever a requester ack appears
  always @(negedge clk)
    if (reset) begin
      mon(0, readAck0, writeAck0, ramIn0);
      mon(1, readAck1, writeAck1, ramIn1);
      chk("proto_error", protoError, exp_err_cyc >= 0 && cyc >= exp_err_cyc);
    end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0, n0, ls;
    readReq0 = 0; writeReq0 = 0; readReq1 = 0; writeReq1 = 0;
    ramAddress0 = 0; ramOut0 = 0; ramAddress1 = 0; ramOut1 = 0;
    memReadAck = 0; memWriteAck = 0; memIn = 0;
    exp_ramin[0] = 0; exp_ramin[1] = 0;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", |{ramIn0, ramIn1, readAck0, writeAck0, readAck1, writeAck1,
        memReadReq, memWriteReq, memAddress, memOut, grant, protoError}, 0);
    reset = 1;
    // simultaneous requests straight out of reset: port 0 first either way
    tick(); issue(0, 0, 1, 32'h20, 32'h11111111); issue(1, 1, 0, 32'h30, 0);
    drain();
    chk("t2_count", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("t2_first", gseq[0], 2'b01);
      chk("t2_first_write", wseq[0], 1);
      chk("t2_second", gseq[1], 2'b10);
    end
    // single read on port 0 with hand-timed RAM ack
    mem[32'h10] = 32'hDEADBEEF; ref_mem[32'h10] = 32'hDEADBEEF;
    auto_ack = 0;
    tick(); issue(0, 1, 0, 32'h10, 0); t0 = cyc;
    tick(); chk("t1_no_early", memReadReq, 0);
    tick(); chk("t1_issue", memReadReq, 1); chk("t1_addr", memAddress, 32'h10); chk("t1_issue_lat", cyc - t0, 2);
    tick(); chk("t1_pulse", memReadReq, 0);
    ram_ack();
    tick();
    chk("t1_ack0", readAck0, 1); chk("t1_ramin0", ramIn0, 32'hDEADBEEF);
    chk("t1_ack1", readAck1, 0); chk("t1_ramin1", ramIn1, seed_val(32'h30)); chk("t1_rtt", cyc - t0, 4);
    drain();
    // fairness: both ports re-request in the same cycle their ack arrives
    gseq.delete(); wseq.delete(); ls = last;
    for (int i = 0; i < 300 && gseq.size() < 6; i++) begin
      tick();
      for (int p = 0; p < 2; p++) if (!busy[p]) rand_issue(p);
    end
    drain();
    chk("t3_count", gseq.size() >= 6, 1);
    for (int i = 0; i < 6 && i < gseq.size(); i++)
`ifdef ARBITER_ROUND_ROBIN_EN
      chk("t3_grant", gseq[i], ((i + ls + 1) % 2) != 0 ? 2'b10 : 2'b01);
`else
      chk("t3_grant", gseq[i], 2'b01);
`endif
    // protocol errors: duplicate request dropped, read+write becomes a write
    auto_ack = 0; n0 = n_issue;
    tick(); issue(1, 1, 0, 32'h140, 0);
    tick(); tick();
    tick(); issue(1, 1, 0, 32'h150, 0);
    tick(); chk("t4_err", protoError, 1);
    ram_ack(); drain();
    chk("t4_one_read", n_issue - n0, 1);
    tick(); issue(0, 1, 1, 32'h24, 32'h5A5A5A5A); drain();
    chk("t4_rw_is_write", wseq[wseq.size() - 1], 1);
    chk("t4_sticky", protoError, 1);
    // non-matching ack during a read is ignored
    auto_ack = 0;
    tick(); issue(0, 1, 0, 32'h18, 0);
    tick(); tick();
    tick(); memWriteAck = 1;
    tick(); chk("t5_no_ack", readAck0 | writeAck0, 0);
    tick(); chk("t5_grant_held", grant, 2'b01); chk("t5_addr_held", memAddress, 32'h18);
    ram_ack();
    tick(); chk("t5_ack", readAck0, 1);
    drain();
    // reset while waiting on the RAM, then a late ack
    auto_ack = 0;
    tick(); issue(1, 1, 0, 32'h160, 0);
    tick(); tick(); tick();
    #2 reset = 0; model_reset();
    #1 chk("t6_reset_outputs", |{ramIn0, ramIn1, readAck0, writeAck0, readAck1, writeAck1,
        memReadReq, memWriteReq, memAddress, memOut, grant, protoError}, 0);
    tick(); tick(); reset = 1;
    tick(); memReadAck = 1; memIn = 32'hFFFFFFFF;
    tick(); tick();
    chk("t6_no_ack", readAck0 | readAck1, 0);
    chk("t6_ramin", ramIn0 | ramIn1, 0);
    chk("t6_idle", |{grant, memReadReq, memWriteReq}, 0);
    auto_ack = 1;
    tick(); issue(1, 1, 0, 32'h160, 0);
    drain();
    // randomized traffic with stray and mismatched RAM acks
    noisy = 1;
    for (int i = 0; i < 600; i++) begin
      tick();
      for (int p = 0; p < 2; p++)
        if (!busy[p] && $urandom_range(0, 2) == 0) rand_issue(p);
        else if (busy[p] && $urandom_range(0, 40) == 0) rand_issue(p);
    end
    noisy = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
